// File: rtl/seq_detector_param.sv
// seq_detector_param
//   Serial sequence detector for a run-time programmable pattern of 1..MAX_LEN
//   bits. Supports overlapping or non-overlapping detection, an input-enable
//   strobe and a saturating match counter. z is a Moore output: it is high for
//   one cycle after each edge that completes the pattern.
//
// Ports
//   clk          clock, all state changes on posedge
//   rst          synchronous active-high reset
//   cfg_load     latch cfg_pattern / cfg_len / cfg_overlap, clear progress
//   cfg_pattern  pattern, bit [len-1] is received first, bit [0] last
//   cfg_len      pattern length, valid 1..MAX_LEN
//   cfg_overlap  1 = overlapping detection, 0 = non-overlapping
//   en           x is valid this cycle
//   x            serial data bit
//   z            detection flag (state == MATCH)
//   armed        a valid configuration is held
//   match_count  detections since last reset/load, saturating
module seq_detector_param #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = $clog2(MAX_LEN) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               en,
    input  logic               x,
    output logic               z,
    output logic               armed,
    output logic [CNT_W-1:0]   match_count
);

    typedef enum logic [1:0] {IDLE, HUNT, MATCH} state_t;

    state_t             state, state_nxt;
    logic [MAX_LEN-1:0] pattern, hist, cand, mask;
    logic [LEN_W-1:0]   len, fill;
    logic [LEN_W:0]     fill_p1;
    logic               overlap;
    logic               cfg_ok, accept, hit;

    assign cfg_ok  = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    assign accept  = en && (state != IDLE) && !cfg_load;
    assign fill_p1 = {1'b0, fill} + {{LEN_W{1'b0}}, 1'b1};

    // History as it would look after shifting in the current bit; also the
    // window compared against the pattern.
    always_comb begin
        cand    = hist << 1;
        cand[0] = x;
    end

    // Only the low len bits of the window take part in the compare.
    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++)
            mask[i] = (LEN_W'(i) < len);
    end

    // fill guards against matching on zeros left over from a clear.
    assign hit = accept && (fill_p1 >= {1'b0, len}) &&
                 (((cand ^ pattern) & mask) == '0);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (cfg_load) begin
            state_nxt = cfg_ok ? HUNT : IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = IDLE;
                HUNT:    state_nxt = hit ? MATCH : HUNT;
                MATCH:   state_nxt = hit ? MATCH : HUNT;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pattern     <= '0;
            len         <= '0;
            overlap     <= 1'b0;
            hist        <= '0;
            fill        <= '0;
            match_count <= '0;
        end else if (cfg_load) begin
            pattern     <= cfg_pattern;
            len         <= cfg_len;
            overlap     <= cfg_overlap;
            hist        <= '0;
            fill        <= '0;
            match_count <= '0;
        end else if (accept) begin
            if (hit && !overlap) begin
                // Non-overlapping: next detection needs len fresh bits.
                hist <= '0;
                fill <= '0;
            end else begin
                hist <= cand;
                fill <= (fill == LEN_W'(MAX_LEN)) ? fill : fill + 1'b1;
            end
            if (hit && (match_count != '1))
                match_count <= match_count + 1'b1;
        end
    end

    assign z     = (state == MATCH);
    assign armed = (state != IDLE);

endmodule

// File: tb/tb_seq_detector_param.sv
module tb_seq_detector_param;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;

    logic               clk = 1'b0;
    logic               rst, cfg_load, cfg_overlap, en, x;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               z, armed, z_s, armed_s;
    logic [7:0]         match_count;
    logic [1:0]         match_count_s;

    always #5 clk = ~clk;

    seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .en(en), .x(x),
        .z(z), .armed(armed), .match_count(match_count)
    );

    // Narrow-counter copy on the same stimulus, for the saturation case.
    seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .en(en), .x(x),
        .z(z_s), .armed(armed_s), .match_count(match_count_s)
    );

    typedef struct {
        logic       ld;
        logic [7:0] pat;
        logic [3:0] len;
        logic       ov;
        logic       rs;
        logic       en;
        logic       x;
        logic       ez;
        logic       ea;
        logic [7:0] ec;
    } vec_t;

    typedef struct {
        int         idx;
        logic       ez;
        logic       ea;
        logic [7:0] ec;
        bit         chk_s;
        logic [1:0] ecs;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   total = 0;
    int   passed = 0;

    task automatic row(input logic ld, input logic [7:0] pat, input logic [3:0] len,
                       input logic ov, input logic rs, input logic e, input logic xi,
                       input logic ez, input logic ea, input logic [7:0] ec);
        vec_t v;
        v.ld = ld; v.pat = pat; v.len = len; v.ov = ov; v.rs = rs;
        v.en = e; v.x = xi; v.ez = ez; v.ea = ea; v.ec = ec;
        tbl.push_back(v);
    endtask

    // accepted bit while armed
    task automatic f(input logic xi, input logic ez, input logic [7:0] ec);
        row(0, 8'h00, 4'd0, 0, 0, 1, xi, ez, 1, ec);
    endtask

    // gap cycle (en=0) while armed
    task automatic g(input logic xi, input logic [7:0] ec);
        row(0, 8'h00, 4'd0, 0, 0, 0, xi, 0, 1, ec);
    endtask

    // bit offered while unconfigured
    task automatic u(input logic xi);
        row(0, 8'h00, 4'd0, 0, 0, 1, xi, 0, 0, 0);
    endtask

    task automatic check();
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            $display("FAIL scoreboard_empty: no expected entry queued");
            return;
        end
        e = sb.pop_front();
        total++;
        if ({z, armed, match_count} !== {e.ez, e.ea, e.ec})
            $display("FAIL step%0d: got z=%b armed=%b cnt=%0d, want z=%b armed=%b cnt=%0d",
                     e.idx, z, armed, match_count, e.ez, e.ea, e.ec);
        else
            passed++;
        if (e.chk_s) begin
            total++;
            if (match_count_s !== e.ecs)
                $display("FAIL sat_step%0d: got cnt2=%0d, want %0d", e.idx, match_count_s, e.ecs);
            else
                passed++;
        end
    endtask

    task automatic drive(input int idx, input vec_t v, input bit chk_s, input logic [1:0] ecs);
        exp_t e;
        rst = v.rs; cfg_load = v.ld; cfg_pattern = v.pat; cfg_len = v.len;
        cfg_overlap = v.ov; en = v.en; x = v.x;
        e.idx = idx; e.ez = v.ez; e.ea = v.ea; e.ec = v.ec; e.chk_s = chk_s; e.ecs = ecs;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check();
    endtask

    initial begin
        rst = 1'b1; cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0;
        cfg_overlap = 1'b0; en = 1'b0; x = 1'b0;

        // reset state, unconfigured ignores input
        row(0, 8'h00, 4'd0, 0, 1, 0, 0, 0, 0, 0);
        u(1);
        // 1010 overlapping over 1010101010
        row(1, 8'h0A, 4'd4, 1, 0, 1, 0, 0, 1, 0);
        f(1,0,0); f(0,0,0); f(1,0,0); f(0,1,1); f(1,0,1);
        f(0,1,2); f(1,0,2); f(0,1,3); f(1,0,3); f(0,1,4);
        // reload while in MATCH, non-overlapping, same stream
        row(1, 8'h0A, 4'd4, 0, 0, 0, 0, 0, 1, 0);
        f(1,0,0); f(0,0,0); f(1,0,0); f(0,1,1); f(1,0,1);
        f(0,0,1); f(1,0,1); f(0,1,2); f(1,0,2); f(0,0,2);
        // len 1, pattern 1: x during load is discarded
        row(1, 8'h01, 4'd1, 1, 0, 1, 1, 0, 1, 0);
        f(1,1,1); f(1,1,2); f(1,1,3); f(0,0,3);
        // gaps do not break a partial match
        row(1, 8'h0A, 4'd4, 1, 0, 0, 0, 0, 1, 0);
        f(1,0,0); f(0,0,0); f(1,0,0);
        g(1,0); g(0,0); g(1,0);
        f(0,1,1); g(0,1);
        // reset mid-pattern, then reload
        row(1, 8'h0A, 4'd4, 1, 0, 0, 0, 0, 1, 0);
        f(1,0,0); f(0,0,0); f(1,0,0);
        row(0, 8'h00, 4'd0, 0, 1, 1, 0, 0, 0, 0);
        u(0); u(1);
        row(1, 8'h0A, 4'd4, 1, 0, 0, 0, 0, 1, 0);
        f(1,0,0); f(0,0,0); f(1,0,0); f(0,1,1);
        // invalid lengths leave detector unarmed
        row(1, 8'h0A, 4'd0, 1, 0, 0, 0, 0, 0, 0);
        u(1); u(0); u(1); u(0);
        row(1, 8'h0A, 4'd9, 1, 0, 0, 0, 0, 0, 0);
        u(1); u(0); u(1); u(0);
        // full-length pattern 11001010, non-overlapping, after leading junk
        row(1, 8'hCA, 4'd8, 0, 0, 0, 0, 0, 1, 0);
        f(0,0,0); f(0,0,0);
        f(1,0,0); f(1,0,0); f(0,0,0); f(0,0,0);
        f(1,0,0); f(0,0,0); f(1,0,0); f(0,1,1);
        f(1,0,1);

        foreach (tbl[i]) drive(i, tbl[i], 1'b0, 2'd0);

        // Saturation: 5 consecutive hits, 8-bit counter counts on, 2-bit holds at 3.
        begin
            vec_t v;
            v = '{ld:0, pat:8'h00, len:4'd0, ov:0, rs:1, en:0, x:0, ez:0, ea:0, ec:8'd0};
            drive(1000, v, 1'b1, 2'd0);
            v = '{ld:1, pat:8'h01, len:4'd1, ov:1, rs:0, en:0, x:0, ez:0, ea:1, ec:8'd0};
            drive(1001, v, 1'b1, 2'd0);
            for (int k = 1; k <= 5; k++) begin
                v = '{ld:0, pat:8'h00, len:4'd0, ov:0, rs:0, en:1, x:1, ez:1, ea:1, ec:8'(k)};
                drive(1001 + k, v, 1'b1, (k > 3) ? 2'd3 : 2'(k));
            end
        end

        if (sb.size() != 0) begin
            total++;
            $display("FAIL scoreboard_leftover: %0d entries unchecked, want 0", sb.size());
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
